sram_block_access_ctrl: RTL

//  Registered SRAM block decoder plus 68k bus-cycle controller for the SRAM region.

---
 rtl/sram_ctrl_pkg.sv | 30 +++
 rtl/sram_wait_counter.sv | 45 ++++
 rtl/sram_block_access_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared types and helpers for the SRAM block access controller.
//   state_e : bus-cycle states (IDLE, WAIT, ACK, BERR)
//   WS_W    : width of the wait-state counter (covers 0..15 wait cycles)
//   clog2   : constant-friendly ceiling log2. The block index width is
//             clog2(NUM_BLOCKS); it is derived inside the controller because
//             NUM_BLOCKS is a per-instance parameter.
// ---------------------------------------------------------------------------
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    BERR = 2'd3
  } state_e;

  localparam int WS_W = 4;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// ---------------------------------------------------------------------------
// sram_wait_counter
// Down-counter that times the wait states of one SRAM bus cycle.
// Ports:
//   Clock      in  system clock, rising edge
//   Reset_H    in  synchronous reset, active-high, clears the count
//   load       in  load load_value on the next edge (wins over dec)
//   load_value in  WS_W-bit value to load
//   dec        in  decrement on the next edge; saturates at zero
//   zero       out high while the registered count equals zero
// ---------------------------------------------------------------------------
module sram_wait_counter
  import sram_ctrl_pkg::*;
(
  input  logic            Clock,
  input  logic            Reset_H,
  input  logic            load,
  input  logic [WS_W-1:0] load_value,
  input  logic            dec,
  output logic            zero
);

  logic [WS_W-1:0] count_q;
  logic [WS_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - WS_W'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset_H) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/sram_block_access_ctrl.sv
// ---------------------------------------------------------------------------
// sram_block_access_ctrl
// Registered SRAM block decoder and 68k bus-cycle controller. An access is
// accepted when the address strobe and the SRAM region decode are both
// active; the block index, direction and write-protect decision are frozen
// on that edge. The controller then drives a one-hot block select, inserts
// WAIT_STATES wait cycles and acknowledges with Dtack_L, or answers a write
// to a protected block with Berr_L.
// Ports:
//   Clock         in   system clock, rising edge
//   Reset_H       in   synchronous reset, active-high
//   Address       in   ADDR_W lower 68k address lines; top BLK_W bits = block
//   SRamSelect_H  in   top-level decode says the access targets SRAM
//   AS_L          in   68k address strobe, active-low
//   RW_H          in   1 = read, 0 = write
//   WrProtect_H   in   bit n write-protects block n
//   Block_H       out  one-hot block select (registered)
//   SramOE_L      out  SRAM output enable for reads (registered)
//   SramWE_L      out  SRAM write enable for writes (registered)
//   Dtack_L       out  data acknowledge (registered)
//   Berr_L        out  bus error (registered)
//   Busy_H        out  high whenever a bus cycle is in progress (registered)
// ---------------------------------------------------------------------------
module sram_block_access_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 17,
  parameter int NUM_BLOCKS  = 4,
  parameter int WAIT_STATES = 1
) (
  input  logic                  Clock,
  input  logic                  Reset_H,
  input  logic [ADDR_W-1:0]     Address,
  input  logic                  SRamSelect_H,
  input  logic                  AS_L,
  input  logic                  RW_H,
  input  logic [NUM_BLOCKS-1:0] WrProtect_H,
  output logic [NUM_BLOCKS-1:0] Block_H,
  output logic                  SramOE_L,
  output logic                  SramWE_L,
  output logic                  Dtack_L,
  output logic                  Berr_L,
  output logic                  Busy_H
);

  localparam int BLK_W = clog2(NUM_BLOCKS);
  // The counter holds the number of wait cycles still to go after the first.
  localparam logic [WS_W-1:0] WS_LOAD =
    WS_W'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  state_e state_q, state_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic rw_q, rw_d;
  logic seen_high_q, seen_high_d;

  logic [NUM_BLOCKS-1:0] block_q, block_d;
  logic oe_l_q, oe_l_d;
  logic we_l_q, we_l_d;
  logic dtack_l_q, dtack_l_d;
  logic berr_l_q, berr_l_d;
  logic busy_q, busy_d;

  logic [BLK_W-1:0] addr_blk;
  logic start;
  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;

  // Shifting the whole address keeps every address line in the expression.
  assign addr_blk = BLK_W'(Address >> (ADDR_W - BLK_W));

  // A new access needs the strobe to have been seen high since the last one
  // started (or since reset), so a strobe held low never retriggers.
  assign start = (state_q == IDLE) && !AS_L && SRamSelect_H && seen_high_q;

  sram_wait_counter u_wait_counter (
    .Clock      (Clock),
    .Reset_H    (Reset_H),
    .load       (cnt_load),
    .load_value (WS_LOAD),
    .dec        (cnt_dec),
    .zero       (cnt_zero)
  );

  // State and output registers.
  always_ff @(posedge Clock) begin
    if (Reset_H) begin
      state_q     <= IDLE;
      blk_q       <= '0;
      rw_q        <= 1'b1;
      seen_high_q <= 1'b0;
      block_q     <= '0;
      oe_l_q      <= 1'b1;
      we_l_q      <= 1'b1;
      dtack_l_q   <= 1'b1;
      berr_l_q    <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      rw_q        <= rw_d;
      seen_high_q <= seen_high_d;
      block_q     <= block_d;
      oe_l_q      <= oe_l_d;
      we_l_q      <= we_l_d;
      dtack_l_q   <= dtack_l_d;
      berr_l_q    <= berr_l_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic. Block, direction and protect decision are captured
  // only on the start edge; later input changes cannot affect the cycle.
  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    rw_d        = rw_q;
    seen_high_d = seen_high_q | AS_L;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          blk_d       = addr_blk;
          rw_d        = RW_H;
          seen_high_d = 1'b0;
          cnt_load    = 1'b1;
          if (!RW_H && WrProtect_H[addr_blk]) begin
            state_d = BERR;
          end else if (WAIT_STATES == 0) begin
            state_d = ACK;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // Releasing the strobe here aborts the cycle without an acknowledge.
        if (AS_L) begin
          state_d = IDLE;
        end else if (cnt_zero) begin
          state_d = ACK;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ACK, BERR: begin
        if (AS_L) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state, so every output is a plain flop and
  // changes on the same edge as the state it belongs to.
  always_comb begin
    block_d   = '0;
    oe_l_d    = 1'b1;
    we_l_d    = 1'b1;
    dtack_l_d = 1'b1;
    berr_l_d  = 1'b1;
    busy_d    = (state_d != IDLE);
    unique case (state_d)
      WAIT, ACK: begin
        block_d   = NUM_BLOCKS'(1) << blk_d;
        oe_l_d    = ~rw_d;
        we_l_d    = rw_d;
        dtack_l_d = (state_d != ACK);
      end
      BERR: begin
        berr_l_d = 1'b0;
      end
      default: begin
      end
    endcase
  end

  assign Block_H  = block_q;
  assign SramOE_L = oe_l_q;
  assign SramWE_L = we_l_q;
  assign Dtack_L  = dtack_l_q;
  assign Berr_L   = berr_l_q;
  assign Busy_H   = busy_q;

endmodule
